mips_hazard_unit: RTL and testbench
===================================

# mips_hazard_unit

Parametrised hazard-detection and forwarding-control unit for the MIPS-lite 5-stage pipeline. Sits beside the ID stage. Tracks destination registers of in-flight instructions in EX, MEM and WB, and drives three things: the IF/ID stall, the branch flush, and registered forward selects for the EX operands. One build parameter selects non-forwarding mode (stall until the producer reaches WB) or forwarding mode (stall only on load-use). Stall and hazard statistics counters are included.

## Interface
- REG_NUM, 32, architectural register count; REG_WIDTH = $clog2(REG_NUM)
- FORWARDING, 0, 0 = non-forwarding interlock, 1 = forwarding with load-use interlock
- CNT_WIDTH, 32, width of statistics counters
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  REG_WIDTH  ID source registers
- id_uses_rs, id_uses_rt  in  1  source actually read by the instruction
- id_rd  in  REG_WIDTH  ID destination register
- id_reg_write  in  1  ID instruction writes the register file
- id_is_load  in  1  ID instruction is LDW
- branch_taken  in  1  branch in EX resolved taken (1-cycle pulse)
- clear_counts  in  1  synchronous clear of both counters
- stall  out  1  hold PC and IF/ID; insert bubble into EX
- flush  out  1  squash IF/ID contents
- fwd_a, fwd_b  out  2  operand source for the instruction now in EX: 00 regfile, 01 EX/MEM aluOut, 10 MEM/WB writeBackData
- stall_count  out  CNT_WIDTH  cycles with stall=1
- hazard_count  out  CNT_WIDTH  distinct hazard events

## Operation
- Scoreboard: three slots (EX, MEM, WB), each holding {valid, rd, reg_write, is_load}. Every cycle EX→MEM→WB shifts.
- EX slot loads the ID fields when id_valid && !stall && !flush. Otherwise it loads a bubble (valid=0).
- A slot "produces r" when valid && reg_write && rd==r && r!=0. Register 0 never hazards or forwards.
- A source "needs r" when id_valid && id_uses_x.
- FORWARDING=0:
  - stall = a needed source is produced by the EX or MEM slot.
  - The WB slot is not a hazard, because the regfile writes before it reads.
  - fwd_a and fwd_b stay 00.
- FORWARDING=1:
  - stall = a needed source is produced by the EX slot and that slot is_load.
  - On EX-slot entry, fwd_x is registered as follows: 01 if the source is produced by the EX slot; else 10 if produced by the MEM slot; else 00. The EX-slot match has priority.
- flush = branch_taken. Flush overrides stall: stall is forced to 0 while flush=1, and the EX slot receives a bubble.
- stall_count increments every cycle stall=1.
- hazard_count increments on cycles where stall=1 && stall_q=0 (stall_q is the registered stall).
- Both counters saturate at all-ones. clear_counts has priority over increment.

## Timing
- Reset (async, rst_n=0): all slots invalid, fwd_a=fwd_b=00, counters=0, stall_q=0. As a consequence stall=0 and flush=0 while branch_taken=0.
- stall and flush are combinational from slot state and ID/EX inputs in the same cycle.
- fwd_a and fwd_b are registered. They change on the edge that moves an instruction into EX; a bubble entry sets them to 00.
- Non-forwarding, dependent instruction directly behind a producer: 2 stall cycles, then issue.
- Forwarding, dependent instruction behind a load: 1 stall cycle, then issue with fwd=10.
- rs and rt both hazarding in the same cycle: one stall, one hazard event.
- Reset asserted mid-stall: stall drops asynchronously with the slots, and counters clear.

## Structure
- The shared package gains:
  - hz_slot_t packed struct {valid, rd, reg_write, is_load}
  - fwd_sel_t enum {FWD_REG=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10}
- One sub-module, hazard_src_match. It is combinational: one source register against the three slots, returning produced-by-EX, produced-by-MEM and load-in-EX flags. It is instantiated twice, once for rs and once for rt.

## Test plan
- Reset with rst_n=0 mid-run → stall=0, fwd=00, stall_count=hazard_count=0 immediately.
- FORWARDING=0: ADD r3←r1,r2 then SUB r4←r3,r5 → stall high 2 cycles; stall_count=2, hazard_count=1; SUB enters EX on cycle 3.
- FORWARDING=1: ADD r3 then SUB using r3 as rs → no stall, fwd_a=01; insert one NOP between them → fwd_a=10.
- FORWARDING=1: LDW r6 then ADD using r6 as rt → 1 stall cycle, then fwd_b=10; hazard_count=1.
- Producer writes r0, consumer reads r0 → no stall, fwd=00 in both modes.
- branch_taken during a stall → flush=1, stall=0, EX bubble; stall_count does not increment that cycle.

Source files
------------

// File: rtl/mips_hazard_pkg.sv
// Shared types for the MIPS-lite hazard unit: scoreboard slot layout,
// forward-select encoding and the slot/register match helper.
package mips_hazard_pkg;

  // Slot rd field is sized for the largest supported register file;
  // narrower register numbers are zero-extended on entry.
  localparam int HZ_RD_W = 8;

  typedef logic [HZ_RD_W-1:0] hz_reg_t;

  typedef struct packed {
    logic    valid;
    hz_reg_t rd;
    logic    reg_write;
    logic    is_load;
  } hz_slot_t;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  localparam hz_slot_t HZ_BUBBLE = '0;

  // A slot produces r when it holds a live register write to r.
  // r0 is hardwired to zero, so it never produces anything.
  function automatic logic slot_produces(input hz_slot_t s, input hz_reg_t r);
    return s.valid && s.reg_write && (s.rd == r) && (r != '0);
  endfunction

endpackage

// File: rtl/mips_hazard_if.sv
// ID-stage / hazard-unit bundle. The pipeline side uses the master
// modport, the hazard unit the slave modport.
interface mips_hazard_if
  import mips_hazard_pkg::*;
#(
  parameter int REG_WIDTH = 5,
  parameter int CNT_WIDTH = 32
);

  logic                 id_valid;
  logic [REG_WIDTH-1:0] id_rs;
  logic [REG_WIDTH-1:0] id_rt;
  logic                 id_uses_rs;
  logic                 id_uses_rt;
  logic [REG_WIDTH-1:0] id_rd;
  logic                 id_reg_write;
  logic                 id_is_load;
  logic                 branch_taken;
  logic                 clear_counts;

  logic                 stall;
  logic                 flush;
  fwd_sel_t             fwd_a;
  fwd_sel_t             fwd_b;
  logic [CNT_WIDTH-1:0] stall_count;
  logic [CNT_WIDTH-1:0] hazard_count;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
    output id_reg_write, id_is_load, branch_taken, clear_counts,
    input  stall, flush, fwd_a, fwd_b, stall_count, hazard_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
    input  id_reg_write, id_is_load, branch_taken, clear_counts,
    output stall, flush, fwd_a, fwd_b, stall_count, hazard_count
  );

endinterface

// File: rtl/mips_hazard_unit_src_match.sv
// Compares one ID source register against the in-flight scoreboard.
// Only EX and MEM matter: the WB producer writes the register file in
// the first half of the cycle, so the ID read already sees its value.
module hazard_src_match
  import mips_hazard_pkg::*;
(
  input  hz_reg_t  src,
  input  hz_slot_t ex_slot,
  input  hz_slot_t mem_slot,
  output logic     prod_ex,
  output logic     prod_mem,
  output logic     load_ex
);

  // MEM-slot load status is irrelevant: a load in MEM already has its data.
  logic unused_mem_load;
  assign unused_mem_load = mem_slot.is_load;

  // Match flags for the two forwardable stages.
  always_comb begin
    prod_ex  = slot_produces(ex_slot, src);
    prod_mem = slot_produces(mem_slot, src);
    load_ex  = prod_ex && ex_slot.is_load;
  end

endmodule

// File: rtl/mips_hazard_unit.sv
// Hazard detection and forwarding control for the MIPS-lite pipeline.
// Keeps a three-slot scoreboard (EX/MEM/WB) of in-flight destinations,
// raises the IF/ID stall and branch flush, registers the EX operand
// forward selects and keeps stall / hazard-event statistics.
module mips_hazard_unit
  import mips_hazard_pkg::*;
#(
  parameter int REG_NUM    = 32,
  parameter int FORWARDING = 0,
  parameter int CNT_WIDTH  = 32
)
(
  input  logic          clk,
  input  logic          rst_n,
  mips_hazard_if.slave  hz
);

  localparam int REG_WIDTH = $clog2(REG_NUM);

  logic [REG_WIDTH-1:0] rs_w;
  logic [REG_WIDTH-1:0] rt_w;
  logic [REG_WIDTH-1:0] rd_w;
  hz_reg_t              rs_x;
  hz_reg_t              rt_x;
  hz_reg_t              rd_x;

  hz_slot_t ex_q,  ex_d;
  hz_slot_t mem_q, mem_d;
  hz_slot_t wb_q,  wb_d;

  fwd_sel_t fwd_a_q, fwd_a_d;
  fwd_sel_t fwd_b_q, fwd_b_d;

  logic                 stall_q, stall_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] haz_cnt_q,   haz_cnt_d;

  logic rs_ex, rs_mem, rs_ld;
  logic rt_ex, rt_mem, rt_ld;
  logic need_rs, need_rt;
  logic stall_c, flush_c, issue;

  // WB slot only exists so the shift chain matches the pipeline; nothing
  // downstream needs to look at it.
  logic unused_wb;
  assign unused_wb = ^wb_q;

  assign rs_w = hz.id_rs;
  assign rt_w = hz.id_rt;
  assign rd_w = hz.id_rd;
  assign rs_x = hz_reg_t'(rs_w);
  assign rt_x = hz_reg_t'(rt_w);
  assign rd_x = hz_reg_t'(rd_w);

  assign need_rs = hz.id_valid && hz.id_uses_rs;
  assign need_rt = hz.id_valid && hz.id_uses_rt;

  hazard_src_match u_match_rs (
    .src      (rs_x),
    .ex_slot  (ex_q),
    .mem_slot (mem_q),
    .prod_ex  (rs_ex),
    .prod_mem (rs_mem),
    .load_ex  (rs_ld)
  );

  hazard_src_match u_match_rt (
    .src      (rt_x),
    .ex_slot  (ex_q),
    .mem_slot (mem_q),
    .prod_ex  (rt_ex),
    .prod_mem (rt_mem),
    .load_ex  (rt_ld)
  );

  // Stall/flush decision; a taken branch squashes ID so it never stalls.
  always_comb begin
    flush_c = hz.branch_taken;
    stall_c = 1'b0;
    if (FORWARDING != 0) begin
      stall_c = (need_rs && rs_ld) || (need_rt && rt_ld);
    end else begin
      stall_c = (need_rs && (rs_ex || rs_mem)) || (need_rt && (rt_ex || rt_mem));
    end
    if (flush_c) begin
      stall_c = 1'b0;
    end
  end

  // Scoreboard shift and forward-select selection for the EX entrant.
  always_comb begin
    issue   = hz.id_valid && !stall_c && !flush_c;
    ex_d    = HZ_BUBBLE;
    mem_d   = ex_q;
    wb_d    = mem_q;
    fwd_a_d = FWD_REG;
    fwd_b_d = FWD_REG;
    if (issue) begin
      ex_d.valid     = 1'b1;
      ex_d.rd        = rd_x;
      ex_d.reg_write = hz.id_reg_write;
      ex_d.is_load   = hz.id_is_load;
    end
    // The current EX producer will sit in MEM next cycle (EX/MEM path);
    // the current MEM producer will sit in WB (MEM/WB path). Nearest wins.
    if (issue && (FORWARDING != 0)) begin
      if (need_rs && rs_ex) begin
        fwd_a_d = FWD_EXMEM;
      end else if (need_rs && rs_mem) begin
        fwd_a_d = FWD_MEMWB;
      end
      if (need_rt && rt_ex) begin
        fwd_b_d = FWD_EXMEM;
      end else if (need_rt && rt_mem) begin
        fwd_b_d = FWD_MEMWB;
      end
    end
  end

  // Saturating statistics; a new hazard event is a rising edge of stall.
  always_comb begin
    stall_d     = stall_c;
    stall_cnt_d = stall_cnt_q;
    haz_cnt_d   = haz_cnt_q;
    if (hz.clear_counts) begin
      stall_cnt_d = '0;
      haz_cnt_d   = '0;
    end else begin
      if (stall_c && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (stall_c && !stall_q && (haz_cnt_q != '1)) begin
        haz_cnt_d = haz_cnt_q + 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= HZ_BUBBLE;
      mem_q       <= HZ_BUBBLE;
      wb_q        <= HZ_BUBBLE;
      fwd_a_q     <= FWD_REG;
      fwd_b_q     <= FWD_REG;
      stall_q     <= 1'b0;
      stall_cnt_q <= '0;
      haz_cnt_q   <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_q     <= stall_d;
      stall_cnt_q <= stall_cnt_d;
      haz_cnt_q   <= haz_cnt_d;
    end
  end

  assign hz.stall        = stall_c;
  assign hz.flush        = flush_c;
  assign hz.fwd_a        = fwd_a_q;
  assign hz.fwd_b        = fwd_b_q;
  assign hz.stall_count  = stall_cnt_q;
  assign hz.hazard_count = haz_cnt_q;

endmodule

// File: tb/tb_mips_hazard_unit.sv
// Directed bench: dut0 is the interlock-only build, dut1 the forwarding build.
module tb_mips_hazard_unit;
  import mips_hazard_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  mips_hazard_if #(.REG_WIDTH(5), .CNT_WIDTH(32)) hz0 ();
  mips_hazard_if #(.REG_WIDTH(5), .CNT_WIDTH(32)) hz1 ();

  mips_hazard_unit #(.REG_NUM(32), .FORWARDING(0), .CNT_WIDTH(32)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz0)
  );

  mips_hazard_unit #(.REG_NUM(32), .FORWARDING(1), .CNT_WIDTH(32)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input int v, input int rs, input int rt, input int urs, input int urt,
                      input int rd, input int rw, input int ld);
    hz0.id_valid     = (v != 0);
    hz0.id_rs        = 5'(rs);
    hz0.id_rt        = 5'(rt);
    hz0.id_uses_rs   = (urs != 0);
    hz0.id_uses_rt   = (urt != 0);
    hz0.id_rd        = 5'(rd);
    hz0.id_reg_write = (rw != 0);
    hz0.id_is_load   = (ld != 0);
  endtask

  task automatic set1(input int v, input int rs, input int rt, input int urs, input int urt,
                      input int rd, input int rw, input int ld);
    hz1.id_valid     = (v != 0);
    hz1.id_rs        = 5'(rs);
    hz1.id_rt        = 5'(rt);
    hz1.id_uses_rs   = (urs != 0);
    hz1.id_uses_rt   = (urt != 0);
    hz1.id_rd        = 5'(rd);
    hz1.id_reg_write = (rw != 0);
    hz1.id_is_load   = (ld != 0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    set0(0, 0, 0, 0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0, 0, 0, 0);
    hz0.branch_taken = 1'b0;
    hz0.clear_counts = 1'b0;
    hz1.branch_taken = 1'b0;
    hz1.clear_counts = 1'b0;
    #2;
    chk("rst_stall0",  32'(hz0.stall), 32'd0);
    chk("rst_flush0",  32'(hz0.flush), 32'd0);
    chk("rst_fwd_a0",  32'(hz0.fwd_a), 32'd0);
    chk("rst_scnt0",   hz0.stall_count, 32'd0);
    chk("rst_hcnt1",   hz1.hazard_count, 32'd0);
    chk("rst_fwd_b1",  32'(hz1.fwd_b), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Interlock build: ADD r3 <- r1,r2 then SUB r4 <- r3,r5
    set0(1, 1, 2, 1, 1, 3, 1, 0);
    #1 chk("nf_add_nostall", 32'(hz0.stall), 32'd0);
    tick();
    set0(1, 3, 5, 1, 1, 4, 1, 0);
    #1 chk("nf_raw_c1", 32'(hz0.stall), 32'd1);
    tick();
    chk("nf_raw_c2", 32'(hz0.stall), 32'd1);
    tick();
    chk("nf_raw_c3", 32'(hz0.stall), 32'd0);
    chk("nf_raw_scnt", hz0.stall_count, 32'd2);
    chk("nf_raw_hcnt", hz0.hazard_count, 32'd1);
    tick();
    set0(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("nf_fwd_a", 32'(hz0.fwd_a), 32'd0);

    // Forwarding build: back-to-back ALU dependency forwards from EX/MEM
    set1(1, 1, 2, 1, 1, 3, 1, 0);
    tick();
    set1(1, 3, 5, 1, 1, 4, 1, 0);
    #1 chk("f_ex_nostall", 32'(hz1.stall), 32'd0);
    tick();
    set1(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("f_ex_fwd_a", 32'(hz1.fwd_a), 32'd1);
    chk("f_ex_fwd_b", 32'(hz1.fwd_b), 32'd0);

    // One NOP between producer and consumer forwards from MEM/WB
    set1(1, 1, 2, 1, 1, 3, 1, 0);
    tick();
    chk("f_add_fwd_a", 32'(hz1.fwd_a), 32'd0);
    set1(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    set1(1, 3, 5, 1, 1, 4, 1, 0);
    #1 chk("f_mem_nostall", 32'(hz1.stall), 32'd0);
    tick();
    set1(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("f_mem_fwd_a", 32'(hz1.fwd_a), 32'd2);

    // Load-use: LDW r6 then ADD r7 <- r1,r6
    set1(1, 1, 0, 1, 0, 6, 1, 1);
    tick();
    set1(1, 1, 6, 1, 1, 7, 1, 0);
    #1 chk("f_lu_stall", 32'(hz1.stall), 32'd1);
    tick();
    chk("f_lu_release", 32'(hz1.stall), 32'd0);
    tick();
    set1(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("f_lu_fwd_b", 32'(hz1.fwd_b), 32'd2);
    chk("f_lu_fwd_a", 32'(hz1.fwd_a), 32'd0);
    chk("f_lu_hcnt", hz1.hazard_count, 32'd1);
    chk("f_lu_scnt", hz1.stall_count, 32'd1);

    // r0 producer / consumer in both builds
    set0(1, 1, 2, 1, 1, 0, 1, 0);
    set1(1, 1, 2, 1, 1, 0, 1, 0);
    tick();
    set0(1, 0, 0, 1, 1, 4, 1, 0);
    set1(1, 0, 0, 1, 1, 4, 1, 0);
    #1 chk("r0_stall0", 32'(hz0.stall), 32'd0);
    chk("r0_stall1", 32'(hz1.stall), 32'd0);
    tick();
    set0(0, 0, 0, 0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("r0_fwd_a1", 32'(hz1.fwd_a), 32'd0);
    chk("r0_fwd_b1", 32'(hz1.fwd_b), 32'd0);

    // Interlock build: rs and rt hit the same producer
    set0(1, 1, 2, 1, 1, 7, 1, 0);
    tick();
    set0(1, 7, 7, 1, 1, 8, 1, 0);
    #1 chk("dual_c1", 32'(hz0.stall), 32'd1);
    tick();
    chk("dual_c2", 32'(hz0.stall), 32'd1);
    tick();
    chk("dual_c3", 32'(hz0.stall), 32'd0);
    chk("dual_scnt", hz0.stall_count, 32'd4);
    chk("dual_hcnt", hz0.hazard_count, 32'd2);
    tick();
    set0(0, 0, 0, 0, 0, 0, 0, 0);

    // Taken branch while stalled
    set0(1, 1, 2, 1, 1, 8, 1, 0);
    tick();
    set0(1, 8, 1, 1, 1, 9, 1, 0);
    #1 chk("br_pre_stall", 32'(hz0.stall), 32'd1);
    hz0.branch_taken = 1'b1;
    #1 chk("br_flush", 32'(hz0.flush), 32'd1);
    chk("br_stall", 32'(hz0.stall), 32'd0);
    tick();
    hz0.branch_taken = 1'b0;
    set0(1, 9, 9, 1, 1, 10, 1, 0);
    #1 chk("br_scnt", hz0.stall_count, 32'd4);
    chk("br_hcnt", hz0.hazard_count, 32'd2);
    chk("br_ex_bubble", 32'(hz0.stall), 32'd0);
    set0(0, 0, 0, 0, 0, 0, 0, 0);

    // Synchronous counter clear
    hz0.clear_counts = 1'b1;
    tick();
    hz0.clear_counts = 1'b0;
    #1 chk("clr_scnt", hz0.stall_count, 32'd0);
    chk("clr_hcnt", hz0.hazard_count, 32'd0);

    // Reset asserted in the middle of a load-use stall
    set1(1, 1, 0, 1, 0, 9, 1, 1);
    tick();
    set1(1, 1, 9, 1, 1, 11, 1, 0);
    #1 chk("mid_pre_stall", 32'(hz1.stall), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("mid_stall", 32'(hz1.stall), 32'd0);
    chk("mid_scnt", hz1.stall_count, 32'd0);
    chk("mid_hcnt", hz1.hazard_count, 32'd0);
    chk("mid_fwd_a", 32'(hz1.fwd_a), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
